// File: rtl/coin_credit_unit.sv
// Coin credit stage: accumulates coin credit, applies purchase deductions, issues refunds.
// Optional idle auto-refund enabled by defining COIN_CREDIT_TIMEOUT_EN.
module coin_credit_unit #(
    parameter int MONEY_W        = 4,
    parameter int MAX_CREDIT     = 15,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_coin_valid,
    input  logic [1:0]         i_coin_code,
    output logic               o_coin_reject,
    output logic [MONEY_W-1:0] o_money,
    input  logic               i_deduct_valid,
    input  logic [MONEY_W-1:0] i_deduct_amt,
    output logic               o_deduct_ok,
    output logic               o_deduct_fail,
    input  logic               i_cancel,
    output logic               o_refund_valid,
    output logic [MONEY_W-1:0] o_refund_amt,
    input  logic               i_refund_ack,
    output logic [1:0]         o_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_REFUND = 2'd2
    } state_t;

    localparam logic [MONEY_W:0] MAX_W = (MONEY_W+1)'(MAX_CREDIT);

    state_t               r_state;
    logic [MONEY_W-1:0]   r_money;
    logic                 r_coin_reject;
    logic                 r_deduct_ok;
    logic                 r_deduct_fail;
    logic                 r_refund_valid;
    logic [MONEY_W-1:0]   r_refund_amt;

    state_t               w_state_nxt;
    logic [MONEY_W-1:0]   w_money_nxt;
    logic                 w_rej_nxt;
    logic                 w_ok_nxt;
    logic                 w_fail_nxt;
    logic                 w_rv_nxt;
    logic [MONEY_W-1:0]   w_ramt_nxt;

    logic [MONEY_W:0]     w_coin_val;
    logic                 w_ded_ok;
    logic [MONEY_W-1:0]   w_after;
    logic [MONEY_W:0]     w_sum;
    logic                 w_coin_ok;
    logic [MONEY_W-1:0]   w_new;
    logic                 w_timeout;

    always_comb begin
        w_coin_val = '0;
        unique case (i_coin_code)
            2'd0:    w_coin_val = (MONEY_W+1)'(1);
            2'd1:    w_coin_val = (MONEY_W+1)'(2);
            2'd2:    w_coin_val = (MONEY_W+1)'(5);
            default: w_coin_val = (MONEY_W+1)'(10);
        endcase
    end

    // Deduction is resolved first; the coin is checked against the post-deduction credit.
    assign w_ded_ok  = i_deduct_valid && (i_deduct_amt <= r_money);
    assign w_after   = w_ded_ok ? (r_money - i_deduct_amt) : r_money;
    assign w_sum     = {1'b0, w_after} + w_coin_val;
    assign w_coin_ok = i_coin_valid && (w_sum <= MAX_W);
    assign w_new     = w_coin_ok ? w_sum[MONEY_W-1:0] : w_after;

`ifdef COIN_CREDIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_idle_cnt;
    logic             w_event;

    assign w_event   = (r_state != S_REFUND) && (w_ded_ok || w_coin_ok);
    assign w_timeout = (r_state == S_CREDIT) && !w_event &&
                       (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if (r_state != S_CREDIT || w_state_nxt != S_CREDIT || w_event) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_money_nxt = r_money;
        w_rej_nxt   = 1'b0;
        w_ok_nxt    = 1'b0;
        w_fail_nxt  = 1'b0;
        w_rv_nxt    = r_refund_valid;
        w_ramt_nxt  = r_refund_amt;
        if (r_state == S_REFUND) begin
            w_rej_nxt  = i_coin_valid;
            w_fail_nxt = i_deduct_valid;
            if (i_refund_ack && r_refund_valid) begin
                w_state_nxt = S_IDLE;
                w_money_nxt = '0;
                w_rv_nxt    = 1'b0;
                w_ramt_nxt  = '0;
            end
        end else begin
            w_money_nxt = w_new;
            w_ok_nxt    = w_ded_ok;
            w_fail_nxt  = i_deduct_valid && !w_ded_ok;
            w_rej_nxt   = i_coin_valid && !w_coin_ok;
            if (w_new == '0) begin
                w_state_nxt = S_IDLE;
            end else if (r_state == S_CREDIT && (i_cancel || w_timeout)) begin
                w_state_nxt = S_REFUND;
                w_rv_nxt    = 1'b1;
                w_ramt_nxt  = w_new;
            end else begin
                w_state_nxt = S_CREDIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_money        <= '0;
            r_coin_reject  <= 1'b0;
            r_deduct_ok    <= 1'b0;
            r_deduct_fail  <= 1'b0;
            r_refund_valid <= 1'b0;
            r_refund_amt   <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_money        <= w_money_nxt;
            r_coin_reject  <= w_rej_nxt;
            r_deduct_ok    <= w_ok_nxt;
            r_deduct_fail  <= w_fail_nxt;
            r_refund_valid <= w_rv_nxt;
            r_refund_amt   <= w_ramt_nxt;
        end
    end

    assign o_state        = r_state;
    assign o_money        = r_money;
    assign o_coin_reject  = r_coin_reject;
    assign o_deduct_ok    = r_deduct_ok;
    assign o_deduct_fail  = r_deduct_fail;
    assign o_refund_valid = r_refund_valid;
    assign o_refund_amt   = r_refund_amt;

endmodule

// File: tb/tb_coin_credit_unit.sv
// Scoreboard bench for coin_credit_unit: directed vectors push expectations,
// a monitor pops one per clock and compares all outputs.
module tb_coin_credit_unit;

    typedef struct packed {
        logic [3:0] money;
        logic [1:0] st;
        logic       rej;
        logic       ok;
        logic       fail;
        logic       rv;
        logic [3:0] ramt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       coin_reject;
    logic [3:0] money;
    logic       deduct_valid;
    logic [3:0] deduct_amt;
    logic       deduct_ok;
    logic       deduct_fail;
    logic       cancel;
    logic       refund_valid;
    logic [3:0] refund_amt;
    logic       refund_ack;
    logic [1:0] state;

    int   n_checks;
    int   n_pass;
    exp_t q[$];

    coin_credit_unit #(
        .MONEY_W(4),
        .MAX_CREDIT(15),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_coin_valid  (coin_valid),
        .i_coin_code   (coin_code),
        .o_coin_reject (coin_reject),
        .o_money       (money),
        .i_deduct_valid(deduct_valid),
        .i_deduct_amt  (deduct_amt),
        .o_deduct_ok   (deduct_ok),
        .o_deduct_fail (deduct_fail),
        .i_cancel      (cancel),
        .o_refund_valid(refund_valid),
        .o_refund_amt  (refund_amt),
        .i_refund_ack  (refund_ack),
        .o_state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t actual();
        exp_t a;
        a.money = money;
        a.st    = state;
        a.rej   = coin_reject;
        a.ok    = deduct_ok;
        a.fail  = deduct_fail;
        a.rv    = refund_valid;
        a.ramt  = refund_amt;
        return a;
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = actual();
        n_checks++;
        if (a === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got money=%0d st=%0d rej=%0b ok=%0b fail=%0b rv=%0b ramt=%0d, need money=%0d st=%0d rej=%0b ok=%0b fail=%0b rv=%0b ramt=%0d",
                     name, a.money, a.st, a.rej, a.ok, a.fail, a.rv, a.ramt,
                     e.money, e.st, e.rej, e.ok, e.fail, e.rv, e.ramt);
        end
    endtask

    // Monitor: outputs from inputs driven at the previous negedge
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            check("scoreboard", q.pop_front());
        end
    end

    task automatic step(input logic cv, input logic [1:0] cc,
                        input logic dv, input logic [3:0] da,
                        input logic can, input logic ack,
                        input logic [3:0] e_money, input logic [1:0] e_st,
                        input logic e_rej, input logic e_ok, input logic e_fail,
                        input logic e_rv, input logic [3:0] e_ramt);
        exp_t e;
        @(negedge clk);
        coin_valid   = cv;
        coin_code    = cc;
        deduct_valid = dv;
        deduct_amt   = da;
        cancel       = can;
        refund_ack   = ack;
        e.money = e_money;
        e.st    = e_st;
        e.rej   = e_rej;
        e.ok    = e_ok;
        e.fail  = e_fail;
        e.rv    = e_rv;
        e.ramt  = e_ramt;
        q.push_back(e);
    endtask

    initial begin
        exp_t z;
        n_checks     = 0;
        n_pass       = 0;
        z            = '0;
        rst_n        = 1'b0;
        coin_valid   = 1'b0;
        coin_code    = 2'd0;
        deduct_valid = 1'b0;
        deduct_amt   = 4'd0;
        cancel       = 1'b0;
        refund_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset", z);
        @(negedge clk);
        rst_n = 1'b1;

        //    cv cc dv da  can ack | money st rej ok fail rv ramt
        step(1, 2, 0, 0,  0, 0,     5, 1, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0,  0, 0,    10, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0,  0, 0,    12, 1, 0, 0, 0, 0, 0);
        step(1, 3, 0, 0,  0, 0,    12, 1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0,  0, 0,    14, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0,  0, 0,    15, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0,  0, 0,    15, 1, 1, 0, 0, 0, 0);
        step(1, 3, 0, 0,  0, 0,    15, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 3,  0, 0,    12, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 12, 0, 0,     0, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0,  0, 0,     2, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0,  0, 0,     3, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 4,  0, 0,     3, 1, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0,  0, 0,     3, 1, 0, 1, 0, 0, 0);
        step(1, 2, 0, 0,  0, 0,     8, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0,  0, 0,     9, 1, 0, 0, 0, 0, 0);
        step(1, 3, 1, 8,  0, 0,    11, 1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 15, 0, 0,    11, 1, 0, 0, 1, 0, 0);
        step(0, 0, 1, 12, 0, 0,    11, 1, 0, 0, 1, 0, 0);
        step(0, 0, 1, 4,  0, 0,     7, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0,  1, 0,     7, 2, 0, 0, 0, 1, 7);
        step(1, 0, 0, 0,  0, 0,     7, 2, 1, 0, 0, 1, 7);
        step(0, 0, 1, 1,  0, 0,     7, 2, 0, 0, 1, 1, 7);
        step(0, 0, 0, 0,  0, 0,     7, 2, 0, 0, 0, 1, 7);
        step(0, 0, 0, 0,  1, 0,     7, 2, 0, 0, 0, 1, 7);
        step(0, 0, 0, 0,  0, 1,     0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0,  0, 1,     0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0,  1, 0,     0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0,  1, 0,     2, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0,  1, 0,     3, 2, 0, 0, 0, 1, 3);
        step(0, 0, 0, 0,  0, 1,     0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0,  0, 0,     1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1,  1, 0,     0, 0, 0, 1, 0, 0, 0);
        step(1, 2, 0, 0,  0, 0,     5, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0,  1, 0,     5, 2, 0, 0, 0, 1, 5);
        step(0, 0, 0, 0,  0, 0,     5, 2, 0, 0, 0, 1, 5);

        // Asynchronous reset while a refund is pending
        @(posedge clk);
        #1;
        @(negedge clk);
        coin_valid   = 1'b0;
        deduct_valid = 1'b0;
        cancel       = 1'b0;
        refund_ack   = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("async_reset_refund", z);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0,  0, 0,     0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0,  0, 1,     0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0,  0, 0,     0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending, need 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/coin_credit_unit.md
Name: coin_credit_unit

Overview:
- Upstream stage of the customer purchase logic: turns coin insertions into the running credit value (`money`) the purchase stage checks against price × amount.
- Accepts a purchase deduction handshake from the purchase stage.
- Handles customer cancel by presenting a refund to the change dispenser through a valid/ack handshake.
- All outputs are registered.

Parameters:
- MONEY_W, 4, width of credit and all money values.
- MAX_CREDIT, 15, highest credit the unit may hold; must be ≤ 2^MONEY_W − 1.
- TIMEOUT_CYCLES, 1000, idle cycles in CREDIT before auto-refund (only used with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- coin_valid  in  1  one-cycle strobe, coin presented.
- coin_code  in  2  denomination: 0→1, 1→2, 2→5, 3→10.
- coin_reject  out  1  one-cycle pulse, coin returned to customer.
- money  out  MONEY_W  current credit.
- deduct_valid  in  1  one-cycle strobe from purchase stage.
- deduct_amt  in  MONEY_W  amount to deduct.
- deduct_ok  out  1  one-cycle pulse, deduction applied.
- deduct_fail  out  1  one-cycle pulse, deduction refused.
- cancel  in  1  one-cycle strobe, customer cancel.
- refund_valid  out  1  refund pending.
- refund_amt  out  MONEY_W  amount to return, stable while refund_valid.
- refund_ack  in  1  dispenser accepted refund.
- state  out  2  0=IDLE, 1=CREDIT, 2=REFUND.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset value of every output: money=0, state=IDLE, coin_reject=0, deduct_ok=0, deduct_fail=0, refund_valid=0, refund_amt=0.
- Reset asserted mid-refund drops refund_valid immediately and clears credit; no refund is re-issued.
- Result latency: all pulse outputs and money updates appear the cycle after the strobe (1-cycle latency).
- Coin_reject, deduct_ok and deduct_fail are single-cycle pulses. Back-to-back strobes produce back-to-back pulses.
- Deduction, in IDLE/CREDIT:
  - If deduct_amt ≤ money: money −= deduct_amt and deduct_ok pulses.
  - Otherwise: money is unchanged and deduct_fail pulses.
  - deduct_amt=0 gives deduct_ok with no change.
- Coin, in IDLE/CREDIT:
  - Let v be the decoded value of coin_code.
  - Accept if (credit after this cycle's deduction) + v ≤ MAX_CREDIT, and add v.
  - Otherwise pulse coin_reject and leave credit unchanged.
  - Compute the sum at MONEY_W+1 bits so overflow never wraps.
- Simultaneous deduct and coin in one cycle: the deduction is evaluated first against the pre-cycle credit, then the coin is checked and added to the result.
- State transitions:
  - IDLE→CREDIT when the new credit is > 0.
  - CREDIT→IDLE when the new credit is 0, e.g. an exact deduction.
- Cancel:
  - In CREDIT: next cycle state=REFUND, refund_valid=1, refund_amt=credit.
  - Cancel is ignored in IDLE and REFUND.
  - Cancel in the same cycle as coin/deduct: the coin and deduct are processed first, and refund_amt equals the resulting credit.
  - If that resulting credit is 0, go to IDLE with no refund.
- REFUND state:
  - Every coin is rejected (coin_reject pulse).
  - Every deduct fails (deduct_fail pulse).
  - money holds the credit until ack.
- Refund handshake:
  - On refund_ack while refund_valid, the next cycle has money=0, refund_valid=0, refund_amt=0, state=IDLE.
  - refund_ack while not refund_valid is ignored.
  - refund_valid stays high indefinitely until acked.

Optional Feature:
- Macro COIN_CREDIT_TIMEOUT_EN.
- Defined:
  - An idle counter counts cycles in CREDIT.
  - It clears on every accepted coin, deduct_ok, and on entering CREDIT.
  - When it reaches TIMEOUT_CYCLES−1 with no event that cycle, the next cycle enters REFUND exactly as a cancel.
  - The counter holds at 0 outside CREDIT.
- Not defined: no counter is built, and credit is held indefinitely.

Test Plan:
- Reset then coins 5,5,2 (codes 2,2,1) → money 0→5→10→12, state CREDIT, no reject.
- Credit 12, coin 10 → coin_reject pulse, money stays 12; coin 2 → money 14, coin 1 → 15, coin 1 → reject.
- Credit 12, deduct_amt=12 → deduct_ok, money 0, state IDLE; credit 3, deduct_amt=4 → deduct_fail, money 3.
- Credit 9, deduct 8 and coin code 3 same cycle → deduct_ok, money 11, no reject.
- Credit 7, cancel → refund_valid=1, refund_amt=7, state REFUND. Coin during REFUND → reject. Ack after 5 cycles → money 0, IDLE.
- With COIN_CREDIT_TIMEOUT_EN, TIMEOUT_CYCLES=8, credit 4 and no activity → refund_valid rises 8 cycles after the last coin with refund_amt=4. A coin at cycle 6 restarts the count.
